// File: rtl/floppy_voice_allocator.sv
// Shares NUM_DRIVES floppy step generators between note-on/note-off events.
// Define FLOPPY_STEAL_EN to steal the oldest drive instead of dropping on overflow.
module floppy_voice_allocator #(
    parameter int NUM_DRIVES = 4,
    parameter int PERIOD_W   = 16
) (
    input  logic                           clock_98k,
    input  logic                           reset,
    input  logic                           all_off,
    input  logic                           note_valid,
    output logic                           note_ready,
    input  logic                           note_on,
    input  logic [6:0]                     note_id,
    input  logic [PERIOD_W-1:0]            note_period,
    output logic [NUM_DRIVES*PERIOD_W-1:0] period_out,
    output logic [NUM_DRIVES-1:0]          drive_busy,
    output logic [7:0]                     drop_count,
    output logic [1:0]                     fsm_state
);

    // A request is accepted on note_valid & note_ready; note_ready depends only on
    // state, reset and all_off, and the request is held internally until COMMIT.
    localparam int IDX_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DRIVES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [NUM_DRIVES-1:0] busy_q;
    logic [6:0]            id_q     [NUM_DRIVES];
    logic [PERIOD_W-1:0]   period_q [NUM_DRIVES];

    logic [IDX_W-1:0]      scan_idx;
    logic                  req_on;
    logic [6:0]            req_id;
    logic [PERIOD_W-1:0]   req_period;
    logic                  match_hit, free_hit;
    logic [IDX_W-1:0]      match_idx, free_idx;

    logic                  cur_busy;
    logic [6:0]            cur_id;
    logic [IDX_W-1:0]      tgt_idx;
    logic                  tgt_write, tgt_clear, tgt_drop;
    logic                  handshake;
    logic                  commit_on;

`ifdef FLOPPY_STEAL_EN
    // Stamps and the sequence counter only matter for victim selection.
    logic [7:0]            stamp_q [NUM_DRIVES];
    logic [7:0]            alloc_seq;
    logic [7:0]            cur_stamp;
    logic [7:0]            cur_age;
    logic                  old_hit;
    logic [IDX_W-1:0]      old_idx;
    logic [7:0]            old_age;
`endif

    assign note_ready = (state == IDLE) && reset && !all_off;
    assign handshake  = note_valid && note_ready;
    assign commit_on  = req_on && (req_period != '0);
    assign drive_busy = busy_q;
    assign fsm_state  = state;

    always_comb begin
        period_out = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            period_out[i*PERIOD_W +: PERIOD_W] = period_q[i];
        end
    end

    always_comb begin
        cur_busy = 1'b0;
        cur_id   = '0;
`ifdef FLOPPY_STEAL_EN
        cur_stamp = '0;
`endif
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_busy = busy_q[i];
                cur_id   = id_q[i];
`ifdef FLOPPY_STEAL_EN
                cur_stamp = stamp_q[i];
`endif
            end
        end
    end

`ifdef FLOPPY_STEAL_EN
    assign cur_age = alloc_seq - cur_stamp;
`endif

    always_comb begin
        tgt_idx   = match_idx;
        tgt_write = 1'b0;
        tgt_clear = 1'b0;
        tgt_drop  = 1'b0;
        if (commit_on) begin
            if (match_hit) begin
                tgt_write = 1'b1;
            end else if (free_hit) begin
                tgt_idx   = free_idx;
                tgt_write = 1'b1;
            end else begin
`ifdef FLOPPY_STEAL_EN
                tgt_idx   = old_idx;
                tgt_write = 1'b1;
`else
                tgt_drop  = 1'b1;
`endif
            end
        end else if (match_hit) begin
            tgt_clear = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (all_off) state_next = IDLE;
    end

    always_ff @(posedge clock_98k) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock_98k) begin
        if (!reset) begin
            busy_q     <= '0;
            drop_count <= '0;
            scan_idx   <= '0;
            req_on     <= 1'b0;
            req_id     <= '0;
            req_period <= '0;
            match_hit  <= 1'b0;
            free_hit   <= 1'b0;
            match_idx  <= '0;
            free_idx   <= '0;
            for (int i = 0; i < NUM_DRIVES; i++) begin
                id_q[i]     <= '0;
                period_q[i] <= '0;
            end
`ifdef FLOPPY_STEAL_EN
            alloc_seq <= '0;
            old_hit   <= 1'b0;
            old_idx   <= '0;
            old_age   <= '0;
            for (int i = 0; i < NUM_DRIVES; i++) stamp_q[i] <= '0;
`endif
        end else if (all_off) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_DRIVES; i++) period_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        req_on     <= note_on;
                        req_id     <= note_id;
                        req_period <= note_period;
                        scan_idx   <= '0;
                        match_hit  <= 1'b0;
                        free_hit   <= 1'b0;
`ifdef FLOPPY_STEAL_EN
                        old_hit    <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (cur_busy && (cur_id == req_id) && !match_hit) begin
                        match_hit <= 1'b1;
                        match_idx <= scan_idx;
                    end
                    if (!cur_busy && !free_hit) begin
                        free_hit <= 1'b1;
                        free_idx <= scan_idx;
                    end
`ifdef FLOPPY_STEAL_EN
                    // Strict compare keeps the lowest index on equal ages.
                    if (cur_busy && (!old_hit || (cur_age > old_age))) begin
                        old_hit <= 1'b1;
                        old_idx <= scan_idx;
                        old_age <= cur_age;
                    end
`endif
                    scan_idx <= scan_idx + 1'b1;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DRIVES; i++) begin
                        if (tgt_idx == IDX_W'(i)) begin
                            if (tgt_write) begin
                                busy_q[i]   <= 1'b1;
                                id_q[i]     <= req_id;
                                period_q[i] <= req_period;
`ifdef FLOPPY_STEAL_EN
                                stamp_q[i]  <= alloc_seq;
`endif
                            end
                            if (tgt_clear) begin
                                busy_q[i]   <= 1'b0;
                                period_q[i] <= '0;
                            end
                        end
                    end
`ifdef FLOPPY_STEAL_EN
                    if (tgt_write) alloc_seq <= alloc_seq + 8'd1;
`endif
                    if (tgt_drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_voice_allocator.sv
// Testbench for floppy_voice_allocator: random and directed note events scored
// against a queue-based reference model; honours FLOPPY_STEAL_EN like the design.
module tb_floppy_voice_allocator;

    localparam int N  = 4;
    localparam int PW = 16;
    localparam int SW = N*PW + N + 8;
    localparam int EW = 2*SW;

    logic            clk = 1'b0;
    logic            reset;
    logic            all_off;
    logic            note_valid;
    logic            note_ready;
    logic            note_on;
    logic [6:0]      note_id;
    logic [PW-1:0]   note_period;
    logic [N*PW-1:0] period_out;
    logic [N-1:0]    drive_busy;
    logic [7:0]      drop_count;
    logic [1:0]      fsm_state;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b1;

    logic [EW-1:0] exp_q[$];

    // Reference model state
    bit            m_busy  [N];
    logic [6:0]    m_id    [N];
    logic [PW-1:0] m_per   [N];
    logic [7:0]    m_stamp [N];
    logic [7:0]    m_seq;
    int            m_drop;

    floppy_voice_allocator #(.NUM_DRIVES(N), .PERIOD_W(PW)) dut (
        .clock_98k   (clk),
        .reset       (reset),
        .all_off     (all_off),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_on     (note_on),
        .note_id     (note_id),
        .note_period (note_period),
        .period_out  (period_out),
        .drive_busy  (drive_busy),
        .drop_count  (drop_count),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] model_snap();
        logic [N*PW-1:0] pv;
        logic [N-1:0]    bv;
        for (int i = 0; i < N; i++) begin
            pv[i*PW +: PW] = m_per[i];
            bv[i]          = m_busy[i];
        end
        return {pv, bv, 8'(m_drop)};
    endfunction

    function automatic logic [SW-1:0] dut_snap();
        return {period_out, drive_busy, drop_count};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0; m_id[i] = '0; m_per[i] = '0; m_stamp[i] = '0;
        end
        m_seq  = '0;
        m_drop = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_per[i]  = '0;
        end
    endtask

    // Applies one request following the allocation rules directly.
    task automatic model_apply(input bit on, input logic [6:0] id, input logic [PW-1:0] p);
        int match = -1;
        int free  = -1;
        int tgt   = -1;
        for (int i = N-1; i >= 0; i--) begin
            if (m_busy[i] && m_id[i] == id) match = i;
            if (!m_busy[i]) free = i;
        end
        if (on && p != 0) begin
            if (match >= 0)     tgt = match;
            else if (free >= 0) tgt = free;
            else begin
`ifdef FLOPPY_STEAL_EN
                int best_age = -1;
                for (int i = 0; i < N; i++) begin
                    int age = (int'(m_seq) - int'(m_stamp[i]) + 256) % 256;
                    if (age > best_age) begin
                        best_age = age;
                        tgt = i;
                    end
                end
`else
                if (m_drop < 255) m_drop++;
`endif
            end
            if (tgt >= 0) begin
                m_busy[tgt]  = 1'b1;
                m_id[tgt]    = id;
                m_per[tgt]   = p;
                m_stamp[tgt] = m_seq;
                m_seq        = m_seq + 8'd1;
            end
        end else if (match >= 0) begin
            m_busy[match] = 1'b0;
            m_per[match]  = '0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input bit on, input logic [6:0] id, input logic [PW-1:0] p);
        logic [SW-1:0] pre;
        int t = 0;
        @(negedge clk);
        while (!note_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!note_ready) begin
            chk("ready_timeout", 1'b0, 1'b1);
            return;
        end
        note_valid  = 1'b1;
        note_on     = on;
        note_id     = id;
        note_period = p;
        pre = model_snap();
        model_apply(on, id, p);
        exp_q.push_back({pre, model_snap()});
        @(posedge clk);
        #1 note_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (N + 3) @(negedge clk);
    endtask

    task automatic clear_all();
        @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        model_clear();
        chk("all_off_clear", {period_out, drive_busy}, model_snap() >> 8);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            if (mon_en && reset && note_valid && note_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_handshake", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    repeat (N) @(posedge clk);
                    @(negedge clk);
                    chk("before_commit", dut_snap(), e[EW-1:SW]);
                    chk("ready_low_in_flight", note_ready, 1'b0);
                    @(posedge clk);
                    @(negedge clk);
                    chk("after_commit", dut_snap(), e[SW-1:0]);
                    chk("ready_after_commit", note_ready, 1'b1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b0;
        all_off     = 1'b0;
        note_valid  = 1'b1;
        note_on     = 1'b1;
        note_id     = 7'd5;
        note_period = 16'd77;
        model_reset();

        // Reset: outputs quiet and no acceptance while held low
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_outputs", dut_snap(), '0);
            chk("reset_ready", note_ready, 1'b0);
        end
        note_valid = 1'b0;
        reset      = 1'b1;
        #1 chk("ready_after_reset", note_ready, 1'b1);

        // Allocation
        send(1'b1, 7'd60, 16'd200);
        send(1'b1, 7'd64, 16'd150);
        settle();
        chk("alloc_periods", period_out, {16'd0, 16'd0, 16'd150, 16'd200});
        chk("alloc_busy", drive_busy, 4'b0011);

        // Retrigger and release
        send(1'b1, 7'd60, 16'd300);
        settle();
        chk("retrigger_period", period_out, {16'd0, 16'd0, 16'd150, 16'd300});
        send(1'b0, 7'd60, 16'd0);
        settle();
        chk("release_periods", period_out, {16'd0, 16'd0, 16'd150, 16'd0});
        chk("release_busy", drive_busy, 4'b0010);
        send(1'b0, 7'd99, 16'd0);
        settle();
        chk("nomatch_off_periods", period_out, {16'd0, 16'd0, 16'd150, 16'd0});
        chk("nomatch_off_busy", drive_busy, 4'b0010);

        // Overflow: ids 1..5 onto an empty bank
        clear_all();
        for (int k = 1; k <= 5; k++) send(1'b1, 7'(k), 16'(k*10));
        settle();
        chk("overflow_busy", drive_busy, 4'b1111);
`ifdef FLOPPY_STEAL_EN
        chk("overflow_steal_periods", period_out, {16'd40, 16'd30, 16'd20, 16'd50});
        chk("overflow_steal_drop", drop_count, 8'd0);
`else
        chk("overflow_drop_periods", period_out, {16'd40, 16'd30, 16'd20, 16'd10});
        chk("overflow_drop_count", drop_count, 8'd1);
        for (int k = 0; k < 300; k++) send(1'b1, 7'd100, 16'd999);
        settle();
        chk("drop_saturates", drop_count, 8'd255);
`endif

        // Random traffic over a small id space so matches are frequent
        clear_all();
        for (int k = 0; k < 120; k++) begin
            logic [PW-1:0] p;
            p = ($urandom_range(0, 5) == 0) ? '0 : PW'($urandom_range(1, 65535));
            send($urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)), p);
            if ($urandom_range(0, 29) == 0) begin
                settle();
                clear_all();
            end
        end
        settle();

        // Abort: all_off during SCAN with drives 0-2 busy
        clear_all();
        send(1'b1, 7'd10, 16'd100);
        send(1'b1, 7'd11, 16'd110);
        send(1'b1, 7'd12, 16'd120);
        settle();
        chk("abort_setup_busy", drive_busy, 4'b0111);
        mon_en = 1'b0;
        @(negedge clk);
        note_valid  = 1'b1;
        note_on     = 1'b1;
        note_id     = 7'd13;
        note_period = 16'd130;
        @(posedge clk);
        #1 note_valid = 1'b0;
        @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        chk("abort_periods", period_out, '0);
        chk("abort_busy", drive_busy, '0);
        chk("abort_ready_low", note_ready, 1'b0);
        all_off = 1'b0;
        model_clear();
        #1 chk("abort_ready_high", note_ready, 1'b1);
        settle();
        chk("abort_not_applied", dut_snap(), model_snap());
        mon_en = 1'b1;

        // Post-abort request still allocates normally
        send(1'b1, 7'd20, 16'd222);
        settle();
        chk("post_abort_alloc", period_out, {16'd0, 16'd0, 16'd0, 16'd222});

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
